req_grant_arbiter: RTL and testbench

// - Shares one resource among N requesters; grant selection uses an N:log2(N) priority-encode stage.
// - Registered one-hot grant, held until release or hold timeout.
// - Sits in front of the shared datapath; the requester index drives its select mux.

---
 rtl/req_grant_arbiter.sv | 177 +++++++++++++++++
 tb/tb_req_grant_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/req_grant_arbiter.sv
// rtl/req_grant_arbiter.sv - N-way request/grant arbiter with registered one-hot grant and hold timeout
//
// Purpose: shares one resource among N requesters. A winner is chosen by a
// priority-encode stage. The winner holds a registered one-hot grant until it
// drops its request, or until it has held the grant for MAX_HOLD cycles.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   req        in   N      level request per requester
//   gnt        out  N      one-hot grant, registered
//   gnt_valid  out  1      |gnt, registered
//   gnt_idx    out  IDX_W  binary index of granted requester, registered
//   timeout    out  1      1-cycle pulse when a grant is revoked at MAX_HOLD
//
// Option macro ROUND_ROBIN_EN: when defined, the search starts at rr_ptr
// (last granted index + 1) and ascends with wrap. When undefined, the
// highest set index wins.

module req_grant_arbiter #(
    parameter int N        = 8,
    parameter int IDX_W    = $clog2(N),
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             timeout
);

    localparam int               HCW       = $clog2(MAX_HOLD) + 1;
    localparam logic [HCW-1:0]   HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic [N-1:0]     ONE_HOT0  = N'(1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [HCW-1:0]   hold_cnt;
    logic [HCW-1:0]   hold_cnt_nx;
    logic [N-1:0]     gnt_nx;
    logic [IDX_W-1:0] idx_nx;
    logic             timeout_nx;
    logic             take;

    logic [N-1:0]     cand;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic             holder_req;

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_ptr_nx;
`endif

    // gnt is zero in IDLE, and the holder's own req bit is zero on release,
    // so masking with ~gnt only matters for the timeout case, where the
    // holder must be excluded from re-arbitration.
    assign cand       = req & ~gnt;
    assign holder_req = req[gnt_idx];

    // Priority encoder. Within the loop the last assignment wins.
    always_comb begin
        win_found = |cand;
        win_idx   = '0;
`ifdef ROUND_ROBIN_EN
        // Scanning offsets downward leaves the smallest offset from rr_ptr
        // as the winner. The index wraps mod N because N is a power of 2.
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[rr_ptr + IDX_W'(i)]) begin
                win_idx = rr_ptr + IDX_W'(i);
            end
        end
`else
        for (int i = 0; i < N; i++) begin
            if (cand[i]) begin
                win_idx = IDX_W'(i);
            end
        end
`endif
    end

    always_comb begin
        state_nx    = state;
        gnt_nx      = gnt;
        idx_nx      = gnt_idx;
        timeout_nx  = 1'b0;
        hold_cnt_nx = hold_cnt;
        take        = 1'b0;
`ifdef ROUND_ROBIN_EN
        rr_ptr_nx   = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (win_found) begin
                    take = 1'b1;
                end
            end
            GRANT: begin
                if (!holder_req) begin
                    if (win_found) begin
                        take = 1'b1;
                    end else begin
                        state_nx    = IDLE;
                        gnt_nx      = '0;
                        idx_nx      = '0;
                        hold_cnt_nx = '0;
                    end
                end else if (hold_cnt == HOLD_LAST) begin
                    timeout_nx = 1'b1;
                    if (win_found) begin
                        take = 1'b1;
                    end else begin
                        // Nobody else is waiting, so the holder is re-granted
                        // and its hold window restarts.
                        hold_cnt_nx = '0;
`ifdef ROUND_ROBIN_EN
                        rr_ptr_nx   = gnt_idx + 1'b1;
`endif
                    end
                end else if (hold_cnt < HOLD_LAST) begin
                    hold_cnt_nx = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
                idx_nx   = '0;
            end
        endcase

        if (take) begin
            state_nx    = GRANT;
            gnt_nx      = ONE_HOT0 << win_idx;
            idx_nx      = win_idx;
            hold_cnt_nx = '0;
`ifdef ROUND_ROBIN_EN
            rr_ptr_nx   = win_idx + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nx;
            gnt       <= gnt_nx;
            gnt_valid <= |gnt_nx;
            gnt_idx   <= idx_nx;
            timeout   <= timeout_nx;
            hold_cnt  <= hold_cnt_nx;
        end
    end

`ifdef ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_nx;
        end
    end
`endif

endmodule

// File: tb/tb_req_grant_arbiter.sv
// tb/tb_req_grant_arbiter.sv - self-checking bench for req_grant_arbiter

module tb_req_grant_arbiter;

    localparam int N        = 8;
    localparam int MAX_HOLD = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic       timeout;

    int tests;
    int fails;

    // Reference model state: current holder (-1 = none), the number of
    // edges it has held the grant, the round-robin start, and the timeout flag.
    int m_holder;
    int m_held;
    int m_rr;
    bit m_to;

    req_grant_arbiter #(.N(N), .IDX_W(3), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Walks the requesters in search order and returns the first one that
    // is requesting and is not excluded.
    function automatic int pick(input logic [7:0] r, input int excl);
        for (int k = 0; k < N; k++) begin
`ifdef ROUND_ROBIN_EN
            int c = (m_rr + k) % N;
`else
            int c = N - 1 - k;
`endif
            if (c != excl && r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_grant(input int w);
        m_holder = w;
        m_held   = 0;
        m_rr     = (w + 1) % N;
    endtask

    initial begin
        int w;
        m_holder = -1; m_held = 0; m_rr = 0; m_to = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_holder = -1; m_held = 0; m_rr = 0; m_to = 1'b0;
            end else begin
                m_to = 1'b0;
                if (m_holder < 0) begin
                    w = pick(req, -1);
                    if (w >= 0) model_grant(w);
                end else if (!req[m_holder]) begin
                    w = pick(req, -1);
                    if (w >= 0) model_grant(w);
                    else begin m_holder = -1; m_held = 0; end
                end else if (m_held == MAX_HOLD - 1) begin
                    m_to = 1'b1;
                    w = pick(req, m_holder);
                    model_grant(w >= 0 ? w : m_holder);
                end else begin
                    m_held++;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        logic [7:0] eg;
        logic [2:0] ei;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                eg = (m_holder < 0) ? 8'h00 : 8'(1 << m_holder);
                ei = (m_holder < 0) ? 3'd0 : 3'(m_holder);
                tests++;
                if (gnt !== eg || gnt_idx !== ei || gnt_valid !== (m_holder >= 0) ||
                    timeout !== m_to || !$onehot0(gnt)) begin
                    fails++;
                    $display("FAIL model t=%0t actual gnt=%h idx=%0d v=%b to=%b required gnt=%h idx=%0d v=%b to=%b",
                             $time, gnt, gnt_idx, gnt_valid, timeout, eg, ei, m_holder >= 0, m_to);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive req, let one edge sample it, then settle 2 time units.
    task automatic cyc(input logic [7:0] r);
        req = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int cur;
        int exp_i;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        req   = 8'h00;
        #12;
        chk("reset_gnt", 32'(gnt), 32'h00);
        chk("reset_valid", 32'(gnt_valid), 32'h0);
        chk("reset_idx", 32'(gnt_idx), 32'h0);
        chk("reset_timeout", 32'(timeout), 32'h0);
        rst_n = 1'b1;
        cyc(8'h00);

        // Single request: latency 1, release returns to idle.
        cyc(8'h04);
        chk("single_gnt", 32'(gnt), 32'h04);
        chk("single_idx", 32'(gnt_idx), 32'h2);
        chk("single_valid", 32'(gnt_valid), 32'h1);
        chk("model_single", 32'(m_holder), 32'h2);
        cyc(8'h00);
        chk("single_drop_gnt", 32'(gnt), 32'h00);
        chk("single_drop_valid", 32'(gnt_valid), 32'h0);

        // Priority and back-to-back hand-over.
        cyc(8'h81);
        chk("prio_gnt", 32'(gnt), 32'h80);
        chk("prio_idx", 32'(gnt_idx), 32'h7);
        cyc(8'h01);
        chk("b2b_gnt", 32'(gnt), 32'h01);
        chk("b2b_idx", 32'(gnt_idx), 32'h0);
        cyc(8'h00);

        // Lone holder: timeout after 16 held cycles, then re-granted.
        cyc(8'h08);
        chk("hold_first", 32'(gnt), 32'h08);
        for (int k = 1; k < MAX_HOLD; k++) begin
            cyc(8'h08);
            chk($sformatf("hold_to_%0d", k), 32'(timeout), 32'h0);
        end
        cyc(8'h08);
        chk("timeout_pulse", 32'(timeout), 32'h1);
        chk("timeout_regrant", 32'(gnt), 32'h08);
        chk("model_timeout", 32'(m_to), 32'h1);
        cyc(8'h08);
        chk("timeout_clear", 32'(timeout), 32'h0);
        cyc(8'h08);
        cyc(8'h08);
        cyc(8'h00);

        // Timeout with a waiting requester hands over to it.
        cyc(8'h09);
`ifndef ROUND_ROBIN_EN
        chk("to2_first", 32'(gnt), 32'h08);
`endif
        for (int k = 1; k < MAX_HOLD; k++) cyc(8'h09);
        cyc(8'h09);
        chk("to2_pulse", 32'(timeout), 32'h1);
`ifndef ROUND_ROBIN_EN
        chk("to2_handover", 32'(gnt), 32'h01);
`endif
        cyc(8'h00);

        // Asynchronous reset in the middle of a grant.
        cyc(8'hFF);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", 32'(gnt), 32'h00);
        chk("async_rst_valid", 32'(gnt_valid), 32'h0);
        chk("async_rst_idx", 32'(gnt_idx), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        chk("post_rst_idle", 32'(gnt), 32'h00);
        cyc(8'hFF);
`ifdef ROUND_ROBIN_EN
        chk("post_rst_gnt", 32'(gnt), 32'h01);
        cur = 0;
`else
        chk("post_rst_gnt", 32'(gnt), 32'h80);
        cur = 7;
`endif

        // Each grantee releases after one cycle while all others keep asking.
        for (int k = 0; k < 8; k++) begin
            cyc(8'hFF & ~(8'h01 << cur));
`ifdef ROUND_ROBIN_EN
            exp_i = (cur + 1) % N;
`else
            exp_i = (cur == 7) ? 6 : 7;
`endif
            chk($sformatf("rotate_%0d", k), 32'(gnt_idx), 32'(exp_i));
            cur = exp_i;
        end

        // Sweep every request pattern from idle.
        for (int v = 0; v < 256; v++) begin
            cyc(8'h00);
            cyc(8'(v));
`ifndef ROUND_ROBIN_EN
            exp_i = (v == 0) ? 0 : $clog2(v + 1) - 1;
            chk($sformatf("sweep_idx_%0d", v), 32'(gnt_idx), 32'(exp_i));
            chk($sformatf("sweep_gnt_%0d", v), 32'(gnt), (v == 0) ? 32'h0 : 32'(1 << exp_i));
`endif
        end
        cyc(8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
